// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - shared types and defaults for the clock edge monitor
package clk_mon_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/clk_mon_sync_edge.sv
// rtl/clk_mon_sync_edge.sv - synchronizer chain for the monitored clock plus edge detect
module clk_mon_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mon,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

endmodule

// File: rtl/clk_edge_monitor.sv
// rtl/clk_edge_monitor.sv - counts edges and phase widths of an asynchronous clock
module clk_edge_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int HALF_MIN    = 1,
  parameter int HALF_MAX    = 4,
  parameter int TARGET      = 10,
  parameter int TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             mon_i,
  output logic [CNT_W-1:0] pos_cnt_o,
  output logic [CNT_W-1:0] neg_cnt_o,
  output logic [CNT_W-1:0] high_w_o,
  output logic [CNT_W-1:0] low_w_o,
  output logic             width_err_o,
  output logic             stuck_err_o,
  output logic             done_o,
  output state_e           state_o
);

  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MIN_V     = CNT_W'(HALF_MIN);
  localparam logic [CNT_W-1:0] MAX_V     = CNT_W'(HALF_MAX);
  localparam logic [CNT_W-1:0] TARGET_V  = CNT_W'(TARGET);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + ONE;
  endfunction

  function automatic logic out_of_range(input logic [CNT_W-1:0] w);
    return (w < MIN_V) || (w > MAX_V);
  endfunction

  logic             s, rise, fall;
  state_e           state_q, state_n;
  logic [CNT_W-1:0] run_q;
  logic [CNT_W-1:0] pos_inc;
  logic             measuring;

  clk_mon_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .mon  (mon_i),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  assign pos_inc = sat_inc(pos_cnt_o);
  assign state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // clr_i outranks enable and every edge-driven transition
  always_comb begin
    state_n   = state_q;
    measuring = 1'b0;
    if (clr_i) begin
      state_n = en_i ? ARM : IDLE;
    end else if (!en_i) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_n = ARM;
        ARM:     if (rise || fall) state_n = MEASURE;
        MEASURE: begin
          measuring = 1'b1;
          if (rise && (pos_inc >= TARGET_V)) state_n = DONE;
        end
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= '0;
      pos_cnt_o   <= '0;
      neg_cnt_o   <= '0;
      high_w_o    <= '0;
      low_w_o     <= '0;
      width_err_o <= 1'b0;
      stuck_err_o <= 1'b0;
      done_o      <= 1'b0;
    end else if (clr_i) begin
      run_q       <= '0;
      pos_cnt_o   <= '0;
      neg_cnt_o   <= '0;
      high_w_o    <= '0;
      low_w_o     <= '0;
      width_err_o <= 1'b0;
      stuck_err_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      run_q <= (rise || fall) ? ONE : sat_inc(run_q);
      if (measuring) begin
        if (rise) begin
          pos_cnt_o <= pos_inc;
          low_w_o   <= run_q;
          if (out_of_range(run_q)) width_err_o <= 1'b1;
        end
        if (fall) begin
          neg_cnt_o <= sat_inc(neg_cnt_o);
          high_w_o  <= run_q;
          if (out_of_range(run_q)) width_err_o <= 1'b1;
        end
        if (run_q >= TIMEOUT_V) stuck_err_o <= 1'b1;
      end
      if (state_n == DONE) done_o <= 1'b1;
    end
  end

endmodule
